// File: rtl/solenoid_pkg.sv
// solenoid_pkg: shared constants for the APB solenoid array.
//   - APB register offsets (byte offsets within the 256-byte slot)
//   - per-channel FSM state encoding
package solenoid_pkg;

  localparam logic [7:0] OFF_FIRE   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_ENABLE = 8'h08;
  localparam logic [7:0] OFF_IRQ    = 8'h0C;
  localparam logic [7:0] CH_BASE    = 8'h10;
  localparam logic [7:0] CH_STRIDE  = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_COOL = 2'd2
  } sol_state_t;

endpackage

// File: rtl/solenoid_channel.sv
// solenoid_channel: one solenoid output, IDLE -> FIRE -> COOL -> IDLE.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   fire        one-cycle strobe, accepted only in IDLE with enable=1
//   enable      channel enable as it will be after this edge; dropping it
//               during FIRE cuts the pulse and moves to COOL
//   pulse_len   pulse length in cycles (0 treated as 1), latched at fire
//   cooldown    cooldown length in cycles, latched at fire
//   trigger     solenoid drive (registered)
//   busy        FIRE or COOL (registered)
//   cooling     COOL (registered)
//   done        combinational, high in the cycle whose edge returns to IDLE
module solenoid_channel
  import solenoid_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fire,
  input  logic             enable,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [CNT_W-1:0] cooldown,
  output logic             trigger,
  output logic             busy,
  output logic             cooling,
  output logic             done
);

  sol_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] c_lat;
  logic             last;
  logic             fire_end;

  assign last     = (cnt == CNT_W'(1));
  // Pulse ends on count-out or when the enable is pulled (safety cut-off).
  assign fire_end = (state == ST_FIRE) && (last || !enable);

  always_comb begin
    done = 1'b0;
    if (fire_end && (c_lat == '0))        done = 1'b1;
    if ((state == ST_COOL) && last)       done = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      c_lat   <= '0;
      trigger <= 1'b0;
      busy    <= 1'b0;
      cooling <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fire && enable) begin
            state   <= ST_FIRE;
            cnt     <= (pulse_len == '0) ? CNT_W'(1) : pulse_len;
            c_lat   <= cooldown;
            trigger <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_FIRE: begin
          if (fire_end) begin
            trigger <= 1'b0;
            if (c_lat == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_COOL;
              cnt     <= c_lat;
              cooling <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_COOL: begin
          if (last) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            cooling <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          trigger <= 1'b0;
          busy    <= 1'b0;
          cooling <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/apb_solenoid_array.sv
// apb_solenoid_array: APB3 slave driving NUM_CH solenoid/trigger outputs,
// each with a programmable pulse width and cooldown.
// Optional feature macro: SOLENOID_IRQ_EN (adds irq port and IRQ register).
// Ports:
//   PCLK, PRESERN                 fabric clock, async active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB3 request
//   PREADY (tied 1), PSLVERR (unmapped offset), PRDATA (comb read data)
//   trigger_signal[NUM_CH]        solenoid drive, active high
//   busy[NUM_CH]                  channel in FIRE or COOL
//   irq                           (SOLENOID_IRQ_EN only) OR of IRQ bits, registered
// Register map: 0x00 FIRE (W), 0x04 STATUS (R), 0x08 ENABLE (RW),
//   0x0C IRQ (W1C, macro only), 0x10+8*i PULSE_LEN, 0x14+8*i COOLDOWN.
module apb_solenoid_array
  import solenoid_pkg::*;
#(
  parameter int          NUM_CH = 4,
  parameter int          CNT_W  = 24,
  parameter logic [23:0] ADDR   = 24'h0
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [31:0]       PRDATA,
  output logic [NUM_CH-1:0] trigger_signal,
  output logic [NUM_CH-1:0] busy
`ifdef SOLENOID_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [7:0] CH_END = CH_BASE + CH_STRIDE * 8'(NUM_CH);

  logic [NUM_CH-1:0]            enable_q;
  logic [NUM_CH-1:0][CNT_W-1:0] pulse_len_q;
  logic [NUM_CH-1:0][CNT_W-1:0] cooldown_q;
  logic [NUM_CH-1:0]            cooling_v;
  logic [NUM_CH-1:0]            done_v;
  logic [NUM_CH-1:0]            fire_v;
  logic [NUM_CH-1:0]            en_nxt;

  logic [7:0]  off;
  logic [7:0]  ch_off;
  logic [2:0]  ch_idx;
  logic        base_hit;
  logic        aligned;
  logic        ch_hit;
  logic        hit;
  logic        wr;
  logic        wr_en;
  logic [31:0] rdata;

  // ---------------- decode ----------------
  assign off      = PADDR[7:0];
  assign base_hit = (PADDR[31:8] == ADDR);
  assign aligned  = (off[1:0] == 2'b00);
  assign ch_off   = off - CH_BASE;
  // Stride is 8 bytes: bits [5:3] pick the channel, bit 2 picks PULSE_LEN/COOLDOWN.
  assign ch_idx   = ch_off[5:3];
  assign ch_hit   = base_hit && aligned && (off >= CH_BASE) && (off < CH_END);

`ifdef SOLENOID_IRQ_EN
  logic [NUM_CH-1:0] irq_q;
`endif

  always_comb begin
    rdata = '0;
    hit   = 1'b0;
    if (base_hit && aligned) begin
      case (off)
        OFF_FIRE:   hit = 1'b1;
        OFF_STATUS: begin
          hit                     = 1'b1;
          rdata[NUM_CH-1:0]       = busy;
          rdata[16+NUM_CH-1:16]   = cooling_v;
        end
        OFF_ENABLE: begin
          hit               = 1'b1;
          rdata[NUM_CH-1:0] = enable_q;
        end
`ifdef SOLENOID_IRQ_EN
        OFF_IRQ: begin
          hit               = 1'b1;
          rdata[NUM_CH-1:0] = irq_q;
        end
`endif
        default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_hit && (ch_idx == 3'(i))) begin
          hit              = 1'b1;
          rdata[CNT_W-1:0] = off[2] ? cooldown_q[i] : pulse_len_q[i];
        end
      end
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & ~hit;
  assign PRDATA  = PSEL ? rdata : 32'h0;

  // ---------------- register file ----------------
  assign wr     = PSEL & PENABLE & PWRITE & hit;
  assign wr_en  = wr && (off == OFF_ENABLE);
  assign fire_v = (wr && (off == OFF_FIRE)) ? PWDATA[NUM_CH-1:0] : '0;
  // Channels see the post-write enable so a cut-off drops the trigger
  // on the cycle right after the ENABLE write.
  assign en_nxt = wr_en ? PWDATA[NUM_CH-1:0] : enable_q;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      enable_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pulse_len_q[i] <= CNT_W'(1);
        cooldown_q[i]  <= '0;
      end
    end else begin
      enable_q <= en_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && ch_hit && (ch_idx == 3'(i))) begin
          if (off[2]) cooldown_q[i]  <= PWDATA[CNT_W-1:0];
          else        pulse_len_q[i] <= PWDATA[CNT_W-1:0];
        end
      end
    end
  end

  // ---------------- channels ----------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    solenoid_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (PCLK),
      .rst_n     (PRESERN),
      .fire      (fire_v[g]),
      .enable    (en_nxt[g]),
      .pulse_len (pulse_len_q[g]),
      .cooldown  (cooldown_q[g]),
      .trigger   (trigger_signal[g]),
      .busy      (busy[g]),
      .cooling   (cooling_v[g]),
      .done      (done_v[g])
    );
  end

  // ---------------- interrupt ----------------
`ifdef SOLENOID_IRQ_EN
  logic [NUM_CH-1:0] irq_clr;
  logic [NUM_CH-1:0] irq_nxt;

  assign irq_clr = (wr && (off == OFF_IRQ)) ? PWDATA[NUM_CH-1:0] : '0;
  // Set wins over a same-cycle write-1-to-clear.
  assign irq_nxt = (irq_q & ~irq_clr) | done_v;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      irq_q <= '0;
      irq   <= 1'b0;
    end else begin
      irq_q <= irq_nxt;
      irq   <= |irq_nxt;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{PWDATA, ch_off};
`else
  logic unused_ok;
  assign unused_ok = ^{PWDATA, ch_off, done_v};
`endif

endmodule
